// File: rtl/round_controller.sv
// Frame-rate sequencer for the two-player game: countdown, round timer,
// respawn holds, loot scoring and winner decode for the HUD/renderer.
//
// Ports:
//   FrameClk    frame clock, the only clock
//   ResetN      synchronous active-low reset
//   Keycode     current keyboard keycode
//   Hit         per-player death pulse, [0]=P1, [1]=P2
//   Deposit     per-player loot-deposit pulse, [0]=P1, [1]=P2
//   SpawnEnable [i]=1 holds player i frozen at its spawn point
//   State       0 Idle, 1 Countdown, 2 Play, 3 Over
//   CountLeft   countdown seconds remaining
//   TimeLeft    round seconds remaining
//   ScoreP1/P2  player scores
//   Winner      00 none, 01 P1, 10 P2, 11 tie (only in Over)
module round_controller #(
    parameter int          FRAMES_PER_SEC = 60,
    parameter int          COUNTDOWN_SECS = 3,
    parameter int          ROUND_SECS     = 60,
    parameter int          RESPAWN_FRAMES = 90,
    parameter int          SCORE_MAX      = 99,
    parameter logic [7:0]  START_KEY      = 8'h28
) (
    input  logic       FrameClk,
    input  logic       ResetN,
    input  logic [7:0] Keycode,
    input  logic [1:0] Hit,
    input  logic [1:0] Deposit,
    output logic [1:0] SpawnEnable,
    output logic [1:0] State,
    output logic [1:0] CountLeft,
    output logic [6:0] TimeLeft,
    output logic [6:0] ScoreP1,
    output logic [6:0] ScoreP2,
    output logic [1:0] Winner
);

    localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
    localparam logic [1:0]    CL_INIT    = 2'(COUNTDOWN_SECS);
    localparam logic [6:0]    TL_INIT    = 7'(ROUND_SECS);
    localparam logic [7:0]    RESP_INIT  = 8'(RESPAWN_FRAMES);
    localparam logic [6:0]    SMAX       = 7'(SCORE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [FW-1:0] frame, frame_n;
    logic [1:0]    count_left, count_left_n;
    logic [6:0]    time_left, time_left_n;
    logic [6:0]    score [2];
    logic [6:0]    score_n [2];
    logic [7:0]    resp [2];
    logic [7:0]    resp_n [2];
    logic [7:0]    prev_key;
    logic          start_edge;
    logic          frame_wrap;

    assign start_edge = (Keycode == START_KEY) && (prev_key != START_KEY);
    assign frame_wrap = (frame == FRAME_LAST);

    always_ff @(posedge FrameClk) begin
        if (!ResetN) begin
            state      <= IDLE;
            frame      <= '0;
            count_left <= CL_INIT;
            time_left  <= TL_INIT;
            score[0]   <= '0;
            score[1]   <= '0;
            resp[0]    <= '0;
            resp[1]    <= '0;
            prev_key   <= 8'h00;
        end else begin
            state      <= state_n;
            frame      <= frame_n;
            count_left <= count_left_n;
            time_left  <= time_left_n;
            score[0]   <= score_n[0];
            score[1]   <= score_n[1];
            resp[0]    <= resp_n[0];
            resp[1]    <= resp_n[1];
            prev_key   <= Keycode;
        end
    end

    always_comb begin
        state_n      = state;
        frame_n      = frame;
        count_left_n = count_left;
        time_left_n  = time_left;
        score_n[0]   = score[0];
        score_n[1]   = score[1];
        resp_n[0]    = resp[0];
        resp_n[1]    = resp[1];

        unique case (state)
            IDLE: begin
                if (start_edge) begin
                    state_n      = COUNT;
                    frame_n      = '0;
                    count_left_n = CL_INIT;
                    time_left_n  = TL_INIT;
                    score_n[0]   = '0;
                    score_n[1]   = '0;
                    resp_n[0]    = '0;
                    resp_n[1]    = '0;
                end
            end
            COUNT: begin
                if (frame_wrap) begin
                    frame_n = '0;
                    if (count_left <= 2'd1) begin
                        count_left_n = '0;
                        state_n      = PLAY;
                    end else begin
                        count_left_n = count_left - 2'd1;
                    end
                end else begin
                    frame_n = frame + FW'(1);
                end
            end
            PLAY: begin
                if (frame_wrap) begin
                    frame_n = '0;
                    if (time_left <= 7'd1) begin
                        time_left_n = '0;
                        state_n     = OVER;
                    end else begin
                        time_left_n = time_left - 7'd1;
                    end
                end else begin
                    frame_n = frame + FW'(1);
                end
                // A player in its respawn window ignores both Hit and
                // Deposit; otherwise Hit wins over Deposit.
                for (int i = 0; i < 2; i++) begin
                    if (resp[i] != 8'd0) begin
                        resp_n[i] = resp[i] - 8'd1;
                    end else if (Hit[i]) begin
                        resp_n[i] = RESP_INIT;
                    end else if (Deposit[i] && (score[i] < SMAX)) begin
                        score_n[i] = score[i] + 7'd1;
                        if (score_n[i] == SMAX) begin
                            state_n = OVER;
                        end
                    end
                end
            end
            OVER: begin
                if (start_edge) begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        SpawnEnable = 2'b11;
        Winner      = 2'b00;
        if (state == PLAY) begin
            SpawnEnable = {resp[1] != 8'd0, resp[0] != 8'd0};
        end
        if (state == OVER) begin
            if (score[0] > score[1]) begin
                Winner = 2'b01;
            end else if (score[1] > score[0]) begin
                Winner = 2'b10;
            end else begin
                Winner = 2'b11;
            end
        end
    end

    assign State     = state;
    assign CountLeft = count_left;
    assign TimeLeft  = time_left;
    assign ScoreP1   = score[0];
    assign ScoreP2   = score[1];

endmodule

// File: tb/tb_round_controller.sv
// Testbench for round_controller: table of per-cycle vectors plus
// hand-written timer-expiry and mid-round reset sequences.
module tb_round_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] key;
    logic [1:0] hit;
    logic [1:0] dep;
    logic [1:0] spawn;
    logic [1:0] st;
    logic [1:0] cl;
    logic [6:0] tl;
    logic [6:0] s1;
    logic [6:0] s2;
    logic [1:0] win;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    round_controller #(
        .FRAMES_PER_SEC(4),
        .COUNTDOWN_SECS(2),
        .ROUND_SECS(3),
        .RESPAWN_FRAMES(5),
        .SCORE_MAX(3),
        .START_KEY(8'h28)
    ) dut (
        .FrameClk(clk),
        .ResetN(rst_n),
        .Keycode(key),
        .Hit(hit),
        .Deposit(dep),
        .SpawnEnable(spawn),
        .State(st),
        .CountLeft(cl),
        .TimeLeft(tl),
        .ScoreP1(s1),
        .ScoreP2(s2),
        .Winner(win)
    );

    typedef struct {
        logic       r;
        logic [7:0] k;
        logic [1:0] h;
        logic [1:0] d;
        logic [1:0] st;
        logic [1:0] sp;
        logic [1:0] cl;
        logic [6:0] tl;
        logic [6:0] s1;
        logic [6:0] s2;
        logic [1:0] w;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [7:0] k, logic [1:0] h,
                                logic [1:0] d, logic [1:0] est,
                                logic [1:0] esp, logic [1:0] ecl,
                                logic [6:0] etl, logic [6:0] es1,
                                logic [6:0] es2, logic [1:0] ew);
        vec_t v;
        v.r = r; v.k = k; v.h = h; v.d = d;
        v.st = est; v.sp = esp; v.cl = ecl; v.tl = etl;
        v.s1 = es1; v.s2 = es2; v.w = ew;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; key = 8'h00; hit = 2'b00; dep = 2'b00;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic go_play();
        int n;
        do_reset();
        key = 8'h28;
        tick();
        key = 8'h00;
        n = 0;
        while (st != 2'd2 && n < 20) begin
            tick();
            n++;
        end
        chk("reach_play", int'(st), 2);
    endtask

    task automatic timer_run(logic with_dep);
        go_play();
        for (int k = 1; k <= 12; k++) begin
            dep = (k == 12 && with_dep) ? 2'b01 : 2'b00;
            tick();
            dep = 2'b00;
            if (k % 4 == 0) chk($sformatf("timeleft_k%0d", k), int'(tl), 3 - k / 4);
            if (k == 11) chk("state_before_expiry", int'(st), 2);
        end
        chk("state_expired", int'(st), 3);
        chk("winner_expired", int'(win), with_dep ? 1 : 3);
        chk("s1_expired", int'(s1), with_dep ? 1 : 0);
        chk("spawn_over", int'(spawn), 3);
    endtask

    initial begin
        rst_n = 1'b0; key = 8'h00; hit = 2'b00; dep = 2'b00;

        //            r  key    h  d    st sp cl tl s1 s2 w
        tbl.push_back(mk(0, 8'h00, 0, 0,  0, 3, 2, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h28, 0, 0,  1, 3, 2, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h28, 0, 0,  1, 3, 2, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h28, 0, 0,  1, 3, 2, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h28, 0, 0,  1, 3, 2, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h28, 0, 0,  1, 3, 1, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h28, 0, 0,  1, 3, 1, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h28, 0, 0,  1, 3, 1, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h28, 0, 0,  1, 3, 1, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h28, 0, 0,  2, 0, 0, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h28, 0, 0,  2, 0, 0, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 1, 0,  2, 1, 0, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 1, 0,  2, 1, 0, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0,  2, 1, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 1,  2, 1, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0,  2, 1, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0,  2, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 1, 3,  2, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 8'h00, 0, 2,  2, 1, 0, 1, 0, 2, 0));
        tbl.push_back(mk(1, 8'h00, 0, 2,  3, 3, 0, 1, 0, 3, 2));
        tbl.push_back(mk(1, 8'h28, 0, 0,  0, 3, 0, 1, 0, 3, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0,  0, 3, 0, 1, 0, 3, 0));
        tbl.push_back(mk(1, 8'h28, 0, 0,  1, 3, 2, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0,  1, 3, 2, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0,  1, 3, 2, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0,  1, 3, 2, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0,  1, 3, 1, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0,  1, 3, 1, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0,  1, 3, 1, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0,  1, 3, 1, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0,  2, 0, 0, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 3,  2, 0, 0, 3, 1, 1, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0,  2, 0, 0, 3, 1, 1, 0));
        tbl.push_back(mk(1, 8'h00, 0, 3,  2, 0, 0, 3, 2, 2, 0));
        tbl.push_back(mk(1, 8'h00, 0, 3,  3, 3, 0, 2, 3, 3, 3));

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].r;
            key   = tbl[i].k;
            hit   = tbl[i].h;
            dep   = tbl[i].d;
            tick();
            checks++;
            if ({st, spawn, cl, tl, s1, s2, win} ==
                {tbl[i].st, tbl[i].sp, tbl[i].cl, tbl[i].tl,
                 tbl[i].s1, tbl[i].s2, tbl[i].w}) begin
                passed++;
            end else begin
                $display("FAIL vec%0d: got st=%0d sp=%b cl=%0d tl=%0d s1=%0d s2=%0d w=%b expected st=%0d sp=%b cl=%0d tl=%0d s1=%0d s2=%0d w=%b",
                         i, st, spawn, cl, tl, s1, s2, win,
                         tbl[i].st, tbl[i].sp, tbl[i].cl, tbl[i].tl,
                         tbl[i].s1, tbl[i].s2, tbl[i].w);
            end
        end
        hit = 2'b00; dep = 2'b00; key = 8'h00;

        timer_run(1'b0);
        timer_run(1'b1);

        go_play();
        dep = 2'b01;
        tick();
        tick();
        dep = 2'b00;
        chk("s1_before_reset", int'(s1), 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_state", int'(st), 0);
        chk("rst_s1", int'(s1), 0);
        chk("rst_s2", int'(s2), 0);
        chk("rst_timeleft", int'(tl), 3);
        chk("rst_countleft", int'(cl), 2);
        chk("rst_spawn", int'(spawn), 3);
        chk("rst_winner", int'(win), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
